// File: rtl/brush_motor_ramp_sequencer.sv
// brush_motor_ramp_sequencer: Avalon-MM ramp/reverse sequencer for one brush_motor_driver.
// Optional BRUSH_SEQ_IRQ_EN adds ins_irq_irq and the sticky irq_flag in status bit 4.
module brush_motor_ramp_sequencer #(
   parameter logic [31:0] ID_VALUE = 32'hEA680103,
   parameter int          DW       = 32
) (
   input  logic          csi_MCLK_clk,
   input  logic          rsi_MRST_reset_n,
   input  logic [2:0]    avs_ctrl_address,
   input  logic          avs_ctrl_write,
   input  logic [31:0]   avs_ctrl_writedata,
   input  logic [3:0]    avs_ctrl_byteenable,
   input  logic          avs_ctrl_read,
   output logic [31:0]   avs_ctrl_readdata,
   output logic          avs_ctrl_waitrequest,
   output logic [DW-1:0] pwm_freq,
   output logic [DW-1:0] pwm_width,
   output logic          motor_on,
   output logic          motor_dir
`ifdef BRUSH_SEQ_IRQ_EN
   ,output logic         ins_irq_irq
`endif
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RUN  = 3'd1;
   localparam logic [2:0] S_STOP = 3'd2;
   localparam logic [2:0] S_REV  = 3'd3;
   localparam logic [2:0] S_DEAD = 3'd4;

   logic [DW-1:0] freq_q, freq_d, tgt_q, tgt_d, step_q, step_d;
   logic [DW-1:0] div_q, div_d, dead_q, dead_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic [2:0]    state_q, state_d;
   logic [DW-1:0] cur_w_q, cur_w_d, tick_cnt_q, tick_cnt_d, dead_cnt_q, dead_cnt_d;
   logic          dir_q, dir_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          tick, en, dir_req, at_tgt, irq_flag;
   logic [DW-1:0] goal, eff_step, ramped;

   function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] w,
                                         input logic [3:0] b);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i+:8] = b[i] ? w[8*i+:8] : o[8*i+:8];
      return r;
   endfunction

   function automatic logic wr_at(input logic [2:0] a);
      return avs_ctrl_write && avs_ctrl_address == a;
   endfunction

   always_comb begin
      freq_d = wr_at(3'd1) ? lanes(freq_q, avs_ctrl_writedata, avs_ctrl_byteenable) : freq_q;
      tgt_d  = wr_at(3'd2) ? lanes(tgt_q,  avs_ctrl_writedata, avs_ctrl_byteenable) : tgt_q;
      step_d = wr_at(3'd3) ? lanes(step_q, avs_ctrl_writedata, avs_ctrl_byteenable) : step_q;
      div_d  = wr_at(3'd4) ? lanes(div_q,  avs_ctrl_writedata, avs_ctrl_byteenable) : div_q;
      dead_d = wr_at(3'd5) ? lanes(dead_q, avs_ctrl_writedata, avs_ctrl_byteenable) : dead_q;
      ctrl_d = wr_at(3'd6) ? avs_ctrl_writedata[1:0] : ctrl_q;
   end

   // >= rather than == so a tick_div lowered below the running count does not wait for wrap
   assign tick       = tick_cnt_q >= div_q;
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + DW'(1);
   assign en         = ctrl_q[0];
   assign dir_req    = ctrl_q[1];
   assign at_tgt     = state_q == S_RUN && cur_w_q == tgt_q;
   assign goal       = state_q == S_RUN ? tgt_q : '0;
   assign eff_step   = step_q == '0 ? DW'(1) : step_q;
   // differences are compared against the step before adding, so no wrap at either end
   assign ramped     = cur_w_q < goal ? ((goal - cur_w_q > eff_step) ? cur_w_q + eff_step : goal)
                     : cur_w_q > goal ? ((cur_w_q - goal > eff_step) ? cur_w_q - eff_step : goal)
                     : cur_w_q;

   always_comb begin
      state_d    = state_q;
      cur_w_d    = tick ? ramped : cur_w_q;
      dead_cnt_d = dead_cnt_q;
      dir_d      = dir_q;
      case (state_q)
         S_IDLE: begin
            cur_w_d = '0;
            if (en) begin
               dir_d   = dir_req;
               state_d = S_RUN;
            end
         end
         S_RUN:  state_d = !en ? S_STOP : (dir_req != dir_q) ? S_REV : S_RUN;
         S_STOP: state_d = en ? ((dir_req == dir_q) ? S_RUN : S_REV)
                              : (cur_w_q == '0) ? S_IDLE : S_STOP;
         S_REV: begin
            if (!en) state_d = S_STOP;
            else if (dir_req == dir_q) state_d = S_RUN;
            else if (cur_w_q == '0) begin
               state_d    = S_DEAD;
               dead_cnt_d = '0;
            end
         end
         S_DEAD: begin
            cur_w_d = '0;
            if (tick && dead_cnt_q >= dead_q) begin
               dir_d   = dir_req;
               state_d = en ? S_RUN : S_IDLE;
            end else if (tick) dead_cnt_d = dead_cnt_q + DW'(1);
         end
         default: begin
            state_d = S_IDLE;
            cur_w_d = '0;
         end
      endcase
   end

`ifdef BRUSH_SEQ_IRQ_EN
   logic at_tgt_q, irq_q;
   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         at_tgt_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         at_tgt_q <= at_tgt;
         irq_q    <= (at_tgt && !at_tgt_q) || (state_q == S_STOP && state_d == S_IDLE) ||
                     (irq_q && !(wr_at(3'd7) && avs_ctrl_writedata[3]));
      end
   end
   assign irq_flag    = irq_q;
   assign ins_irq_irq = irq_q;
`else
   assign irq_flag = 1'b0;
`endif

   always_comb begin
      rdata_d = rdata_q;
      if (avs_ctrl_read)
         case (avs_ctrl_address)
            3'd0:    rdata_d = ID_VALUE;
            3'd1:    rdata_d = freq_q;
            3'd2:    rdata_d = tgt_q;
            3'd3:    rdata_d = step_q;
            3'd4:    rdata_d = div_q;
            3'd5:    rdata_d = dead_q;
            3'd6:    rdata_d = {30'b0, ctrl_q};
            default: rdata_d = {cur_w_q[23:0], 3'b0, irq_flag, at_tgt, state_q};
         endcase
   end

   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         freq_q     <= '0;
         tgt_q      <= '0;
         step_q     <= '0;
         div_q      <= '0;
         dead_q     <= '0;
         ctrl_q     <= '0;
         state_q    <= S_IDLE;
         cur_w_q    <= '0;
         tick_cnt_q <= '0;
         dead_cnt_q <= '0;
         dir_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         freq_q     <= freq_d;
         tgt_q      <= tgt_d;
         step_q     <= step_d;
         div_q      <= div_d;
         dead_q     <= dead_d;
         ctrl_q     <= ctrl_d;
         state_q    <= state_d;
         cur_w_q    <= cur_w_d;
         tick_cnt_q <= tick_cnt_d;
         dead_cnt_q <= dead_cnt_d;
         dir_q      <= dir_d;
         rdata_q    <= rdata_d;
      end
   end

   assign avs_ctrl_readdata    = rdata_q;
   assign avs_ctrl_waitrequest = 1'b0;
   assign pwm_freq             = freq_q;
   assign pwm_width            = cur_w_q;
   assign motor_on             = state_q == S_RUN || state_q == S_STOP || state_q == S_REV;
   assign motor_dir            = dir_q;
endmodule

// File: tb/tb_brush_motor_ramp_sequencer.sv
// tb_brush_motor_ramp_sequencer: directed spec scenarios plus random register traffic,
// every cycle compared against a behavioural model of the sequencer.
module tb_brush_motor_ramp_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [2:0]  addr = '0;
   logic        wr = 1'b0, rd = 1'b0;
   logic [31:0] wd = '0;
   logic [3:0]  be = '0;
   logic [31:0] rdata, freq, width;
   logic        wait_req, on, dir;
`ifdef BRUSH_SEQ_IRQ_EN
   logic        irq;
`endif

   brush_motor_ramp_sequencer dut (
      .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
      .avs_ctrl_address(addr), .avs_ctrl_write(wr), .avs_ctrl_writedata(wd),
      .avs_ctrl_byteenable(be), .avs_ctrl_read(rd), .avs_ctrl_readdata(rdata),
      .avs_ctrl_waitrequest(wait_req), .pwm_freq(freq), .pwm_width(width),
      .motor_on(on), .motor_dir(dir)
`ifdef BRUSH_SEQ_IRQ_EN
      , .ins_irq_irq(irq)
`endif
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // behavioural model: state codes 0 idle, 1 run, 2 stop, 3 reverse-down, 4 dead
   bit [31:0] m_r[8];
   int        m_st;
   bit [31:0] m_cur, m_tc, m_dc, m_rd;
   bit        m_dir, m_irq, m_atp;

   task automatic model_reset();
      foreach (m_r[i]) m_r[i] = '0;
      m_st = 0; m_cur = 0; m_tc = 0; m_dc = 0; m_rd = 0;
      m_dir = 0; m_irq = 0; m_atp = 0;
   endtask

   function automatic bit [31:0] approach(bit [31:0] cur, bit [31:0] t, bit [31:0] step);
      longint e = (step == 0) ? 1 : longint'(step);
      longint c = longint'(cur), g = longint'(t);
      if (c < g) return bit'(0) | 32'((c + e < g) ? c + e : g);
      return 32'((c - e > g) ? c - e : g);
   endfunction

   task automatic model_step();
      bit tick = m_tc >= m_r[4];
      bit en = m_r[6][0], dr = m_r[6][1];
      bit at = (m_st == 1) && (m_cur == m_r[2]);
      int nst = m_st;
      bit [31:0] ncur = tick ? approach(m_cur, (m_st == 1) ? m_r[2] : 0, m_r[3]) : m_cur;
      bit [31:0] ndc = m_dc;
      bit ndir = m_dir;
      bit irq_bit = 0;
      if (m_st == 0) begin
         ncur = 0;
         if (en) begin ndir = dr; nst = 1; end
      end else if (m_st == 1) begin
         if (!en) nst = 2; else if (dr != m_dir) nst = 3;
      end else if (m_st == 2) begin
         if (en) nst = (dr == m_dir) ? 1 : 3; else if (m_cur == 0) nst = 0;
      end else if (m_st == 3) begin
         if (!en) nst = 2;
         else if (dr == m_dir) nst = 1;
         else if (m_cur == 0) begin nst = 4; ndc = 0; end
      end else begin
         ncur = 0;
         if (tick) begin
            if (m_dc >= m_r[5]) begin ndir = dr; nst = en ? 1 : 0; end
            else ndc = m_dc + 1;
         end
      end
`ifdef BRUSH_SEQ_IRQ_EN
      irq_bit = m_irq;
`endif
      if (rd) m_rd = (addr == 0) ? 32'hEA680103 :
                     (addr == 7) ? {m_cur[23:0], 3'b0, irq_bit, at, 3'(m_st)} : m_r[addr];
`ifdef BRUSH_SEQ_IRQ_EN
      m_irq = (at && !m_atp) || (m_st == 2 && nst == 0) || (m_irq && !(wr && addr == 7 && wd[3]));
      m_atp = at;
`endif
      if (wr && addr >= 1 && addr <= 5)
         for (int i = 0; i < 4; i++) if (be[i]) m_r[addr][8*i+:8] = wd[8*i+:8];
      if (wr && addr == 6) m_r[6] = {30'b0, wd[1:0]};
      m_tc = tick ? 0 : m_tc + 1;
      m_st = nst; m_cur = ncur; m_dc = ndc; m_dir = ndir;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check("width", width, m_cur);
      check("on", on, (m_st >= 1 && m_st <= 3));
      check("dir", dir, m_dir);
      check("rdata", rdata, m_rd);
      check("freq", freq, m_r[1]);
      check("wait", wait_req, 0);
`ifdef BRUSH_SEQ_IRQ_EN
      check("irq", irq, m_irq);
`endif
   endtask

   task automatic wreg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
      addr = a; wd = d; be = b; wr = 1;
      cyc();
      wr = 0; be = 0;
   endtask

   task automatic rreg(input logic [2:0] a, output logic [31:0] v);
      addr = a; rd = 1;
      cyc();
      rd = 0;
      v = rdata;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   logic [31:0] v;

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_width", width, 0);
      check("rst_on", on, 0);
      check("rst_dir", dir, 0);
      check("rst_rdata", rdata, 0);
      @(negedge clk);
      rst_n = 1;
      rreg(0, v); check("id", v, 32'hEA680103);
      rreg(7, v); check("status0", v, 0);

      wreg(4, 0); wreg(3, 10); wreg(2, 35); wreg(6, 3);
      cyc();
      cyc(); check("up10", width, 10);
      cyc(); check("up20", width, 20);
      cyc(); check("up30", width, 30);
      cyc(); check("up35", width, 35);
      check("dir_fwd", dir, 1);
      rreg(7, v); check("at_tgt", v[3], 1);

      wreg(6, 2);
      cyc(); check("stop_hold", width, 35);
      cyc(); check("dn25", width, 25);
      cyc(); check("dn15", width, 15);
      cyc(); check("dn5", width, 5);
      cyc(); check("dn0", width, 0);
      cyc(); check("idle_off", on, 0);
      rreg(7, v); check("idle_state", v[2:0], 0);
      wreg(7, 32'h8);

      wreg(3, 20); wreg(2, 20); wreg(6, 3); run(6);
      wreg(5, 3); wreg(4, 1); wreg(6, 1); run(30);
      check("rev_dir", dir, 0);
      check("rev_width", width, 20);

      wreg(4, 0); wreg(3, 0); wreg(2, 3); run(6);
      wreg(2, 32'hFFFF_FFFF); wreg(3, 32'hFFFF_FFFF); run(4);
      check("sat_max", width, 32'hFFFF_FFFF);
      wreg(2, 100); run(2);
      check("sat_down", width, 100);

      wreg(3, 1); run(3); wreg(6, 3); run(5);
      rreg(7, v); check("in_rev", v[2:0], 3);
      #2 rst_n = 0;
      #1;
      model_reset();
      check("arst_width", width, 0);
      check("arst_on", on, 0);
      check("arst_dir", dir, 0);
      check("arst_rdata", rdata, 0);
      @(negedge clk);
      rst_n = 1;
      rreg(7, v); check("post_rst", v, 0);

      for (int i = 0; i < 3000; i++) begin
         int op = $urandom_range(0, 99);
         if (op < 20) begin
            logic [2:0] a = 3'($urandom_range(1, 7));
            logic [31:0] d = (a == 2) ? $urandom_range(0, 200) : (a == 3) ? $urandom_range(0, 30) :
                             (a == 4) ? $urandom_range(0, 3) : (a == 5) ? $urandom_range(0, 5) :
                             $urandom;
            wreg(a, d, 4'($urandom_range(0, 15)));
         end else if (op < 30) rreg(3'($urandom_range(0, 7)), v);
         else cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
